rtc_calendar: RTL and testbench
===============================

// Module: rtc_calendar
// PURPOSE
//  Date counter fed by the RTC time-of-day block's once-per-day strobe (last clock of 23:59:59).
//  Holds a BCD year/month/day and advances it one day per strobe, handling month lengths and Gregorian leap years.
//  A Wishbone slave lets software read the date and set it.
//  The date is also exported on a dedicated output for display and timestamp logic.
// PARAMETERS
//  DEFAULT_DATE  32'h20240101  reset date, format {year[31:16], month[15:8], day[7:0]}, all BCD
// PORTS
//  i_clk        in   1   system clock, the only clock
//  i_rst_n      in   1   asynchronous active-low reset
//  i_ppd        in   1   one-cycle once-per-day strobe from the RTC clock
//  i_wb_cyc     in   1   Wishbone cycle
//  i_wb_stb     in   1   Wishbone strobe
//  i_wb_we      in   1   Wishbone write enable
//  i_wb_data    in   32  write data, same format as DEFAULT_DATE
//  o_wb_ack     out  1   Wishbone acknowledge
//  o_wb_data    out  32  read data = current date
//  o_date       out  32  current date register, direct
//  o_busy       out  1   high while a day-advance ripple is in progress
//  o_ppy        out  1   one-cycle strobe when the year increments
// BEHAVIOUR
//  Clock/reset:
//   - One clock.
//   - Reset is asynchronous and active-low.
//  Reset values:
//   - date = DEFAULT_DATE.
//   - o_wb_ack, o_wb_data, o_busy and o_ppy = 0.
//   - FSM in IDLE, pending flag = 0.
//  FSM states: IDLE, DAY, MONTH, YEAR.
//   - IDLE: i_ppd=1 -> DAY.
//   - DAY: if day >= days_in_month, day <= 8'h01 and go to MONTH. Otherwise BCD increment of day, go to IDLE.
//   - MONTH: if month >= 8'h12, month <= 8'h01 and go to YEAR. Otherwise BCD increment of month, go to IDLE.
//   - YEAR: 4-digit BCD increment, 9999 wraps to 0000. o_ppy=1 for this one cycle. Go to IDLE.
//  Latency from i_ppd at cycle N:
//   - day updated at N+2.
//   - month (if carried) at N+3.
//   - year (if carried) at N+4.
//   - o_busy is high in every non-IDLE state.
//  BCD increment rule: units==9 -> units=0 and tens+1; otherwise units+1. Applies per field/digit.
//  days_in_month:
//   - 31 for months 01,03,05,07,08,10,12.
//   - 30 for months 04,06,09,11.
//   - 29 for month 02 when leap, else 28.
//   - Any invalid month code is treated as 31.
//  Leap (combinational from the current year):
//   - yy = year[7:0]. yy divisible by 4: tens even and units in {0,4,8}, or tens odd and units in {2,6}.
//   - If yy == 8'h00 (century year), use the same test on year[15:8] instead.
//  Out-of-range written day (e.g. 8'h35): the next advance sees day >= length, wraps to 01 and carries the month.
//  Wishbone:
//   - Any cyc&&stb gets o_wb_ack=1 on the next cycle, for exactly 1 cycle.
//   - o_wb_data is registered with the date on the same edge that asserts ack.
//   - Write field masking:
//     - day written unless i_wb_data[7:0] == 8'hff.
//     - month written unless i_wb_data[15:8] == 8'hff.
//     - year written unless i_wb_data[31:16] == 16'hffff.
//  Simultaneous events:
//   - A write in the same cycle as any advance step wins: FSM returns to IDLE and the ripple is aborted.
//   - i_ppd while not IDLE sets a pending flag. The pending advance starts from IDLE on the next cycle.
//   - A write clears the pending flag.
//   - Reset mid-ripple returns all state to reset values immediately.
// STRUCTURE
//  Package rtc_pkg:
//   - cal_state_t enum {IDLE, DAY, MONTH, YEAR}.
//   - Field slice constants: CAL_DAY, CAL_MON, CAL_YEAR.
//   - Functions bcd_inc8 and is_leap_bcd.
//  Sub-module rtc_days_in_month (combinational): month[7:0], leap -> len[7:0] in BCD.
// TESTING
//  1. Reset -> o_date=32'h20240101; o_wb_ack=0, o_busy=0, o_ppy=0.
//  2. Write 32'h20240228, pulse i_ppd -> 32'h20240229. Pulse again -> 32'h20240301, with o_busy high for 2 cycles.
//  3. Century leap years:
//     - Write 32'h21000228, ppd -> 32'h21000301.
//     - Write 32'h20000228, ppd -> 32'h20000229.
//  4. Year rollover:
//     - Write 32'h20241231, ppd -> 32'h20250101 and one o_ppy pulse at N+4.
//     - Write 32'h99991231, ppd -> 32'h00000101.
//  5. Masked write: date 32'h20240115, write 32'hffff03ff -> 32'h20240315. Every stb gets exactly one ack; read data equals o_date.
//  6. Interrupted ripple and reset:
//     - Date 32'h20241231, ppd, then write 32'h20230505 at N+2 -> final 32'h20230505, no o_ppy.
//     - i_rst_n low during the MONTH state -> 32'h20240101.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared types, date-field offsets and BCD helpers for the calendar counter.
// All date fields are packed BCD: {year[31:16], month[15:8], day[7:0]}.
package rtc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DAY   = 2'd1,
    MONTH = 2'd2,
    YEAR  = 2'd3
  } cal_state_t;

  localparam int CAL_DAY  = 0;
  localparam int CAL_MON  = 8;
  localparam int CAL_YEAR = 16;

  function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // 4-digit increment; 9999 wraps to 0000
  function automatic logic [15:0] bcd_inc16(input logic [15:0] v);
    if (v[7:0] == 8'h99) begin
      return {(v[15:8] == 8'h99) ? 8'h00 : bcd_inc8(v[15:8]), 8'h00};
    end
    return {v[15:8], bcd_inc8(v[7:0])};
  endfunction

  // Two-digit BCD divisibility by 4, decided from tens parity and units
  function automatic logic bcd_div4(input logic [7:0] v);
    if (v[4]) begin
      return (v[3:0] == 4'd2) || (v[3:0] == 4'd6);
    end
    return (v[3:0] == 4'd0) || (v[3:0] == 4'd4) || (v[3:0] == 4'd8);
  endfunction

  function automatic logic is_leap_bcd(input logic [15:0] year);
    if (year[7:0] == 8'h00) begin
      return bcd_div4(year[15:8]);
    end
    return bcd_div4(year[7:0]);
  endfunction

endpackage

// File: rtl/rtc_days_in_month.sv
// Month length lookup in BCD; unknown month codes are treated as 31-day months
// so a corrupted month still carries forward cleanly.
module rtc_days_in_month (
  input  logic [7:0] i_month,
  input  logic       i_leap,
  output logic [7:0] o_len
);

  always_comb begin
    o_len = 8'h31;
    case (i_month)
      8'h04, 8'h06, 8'h09, 8'h11: o_len = 8'h30;
      8'h02:                      o_len = i_leap ? 8'h29 : 8'h28;
      default:                    o_len = 8'h31;
    endcase
  end

endmodule

// File: rtl/rtc_calendar.sv
// BCD year/month/day counter advanced by a once-per-day strobe, with a
// Wishbone slave for reading and (field-masked) setting of the date.
module rtc_calendar
  import rtc_pkg::*;
#(
  parameter logic [31:0] DEFAULT_DATE = 32'h20240101
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ppd,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_data,
  output logic [31:0] o_date,
  output logic        o_busy,
  output logic        o_ppy
);

  cal_state_t  state_q, state_d;
  logic [31:0] date_q, date_d;
  logic        pending_q, pending_d;
  logic        ack_q, ack_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        busy_q, busy_d;
  logic        ppy_q, ppy_d;

  logic [7:0]  cur_day;
  logic [7:0]  cur_mon;
  logic [15:0] cur_year;
  logic        leap;
  logic [7:0]  month_len;
  logic        wb_req;
  logic        wb_wr;

  assign cur_day  = date_q[CAL_DAY +: 8];
  assign cur_mon  = date_q[CAL_MON +: 8];
  assign cur_year = date_q[CAL_YEAR +: 16];
  assign leap     = is_leap_bcd(cur_year);

  rtc_days_in_month u_days_in_month (
    .i_month (cur_mon),
    .i_leap  (leap),
    .o_len   (month_len)
  );

  // A held strobe is answered once; the cycle carrying ack is not a new request
  assign wb_req = i_wb_cyc && i_wb_stb && !ack_q;
  assign wb_wr  = wb_req && i_wb_we;

  always_comb begin
    state_d   = state_q;
    date_d    = date_q;
    pending_d = pending_q;
    ppy_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_ppd || pending_q) begin
          state_d   = DAY;
          // both a fresh strobe and a queued one: start one, keep the other
          pending_d = i_ppd && pending_q;
        end
      end
      DAY: begin
        if (i_ppd) pending_d = 1'b1;
        if (cur_day >= month_len) begin
          date_d[CAL_DAY +: 8] = 8'h01;
          state_d              = MONTH;
        end else begin
          date_d[CAL_DAY +: 8] = bcd_inc8(cur_day);
          state_d              = IDLE;
        end
      end
      MONTH: begin
        if (i_ppd) pending_d = 1'b1;
        if (cur_mon >= 8'h12) begin
          date_d[CAL_MON +: 8] = 8'h01;
          state_d              = YEAR;
        end else begin
          date_d[CAL_MON +: 8] = bcd_inc8(cur_mon);
          state_d              = IDLE;
        end
      end
      YEAR: begin
        if (i_ppd) pending_d = 1'b1;
        date_d[CAL_YEAR +: 16] = bcd_inc16(cur_year);
        ppy_d                  = 1'b1;
        state_d                = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Software writes override any ripple step and drop queued advances
    if (wb_wr) begin
      date_d    = date_q;
      state_d   = IDLE;
      pending_d = 1'b0;
      ppy_d     = 1'b0;
      if (i_wb_data[CAL_DAY +: 8] != 8'hff)    date_d[CAL_DAY +: 8]   = i_wb_data[CAL_DAY +: 8];
      if (i_wb_data[CAL_MON +: 8] != 8'hff)    date_d[CAL_MON +: 8]   = i_wb_data[CAL_MON +: 8];
      if (i_wb_data[CAL_YEAR +: 16] != 16'hffff) date_d[CAL_YEAR +: 16] = i_wb_data[CAL_YEAR +: 16];
    end
  end

  always_comb begin
    ack_d     = wb_req;
    wb_data_d = wb_req ? date_q : wb_data_q;
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      date_q    <= DEFAULT_DATE;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      wb_data_q <= 32'h0;
      busy_q    <= 1'b0;
      ppy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      date_q    <= date_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      wb_data_q <= wb_data_d;
      busy_q    <= busy_d;
      ppy_q     <= ppy_d;
    end
  end

  assign o_wb_ack  = ack_q;
  assign o_wb_data = wb_data_q;
  assign o_date    = date_q;
  assign o_busy    = busy_q;
  assign o_ppy     = ppy_q;

endmodule

// File: tb/tb_rtc_calendar.sv
// Self-checking bench for rtc_calendar: directed vector table, timing
// sequences for ripple/abort/reset, and randomized runs against a date model.
module tb_rtc_calendar;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_ppd;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [31:0] i_wb_data;
  logic        o_wb_ack;
  logic [31:0] o_wb_data;
  logic [31:0] o_date;
  logic        o_busy;
  logic        o_ppy;

  rtc_calendar dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_ppd     (i_ppd),
    .i_wb_cyc  (i_wb_cyc),
    .i_wb_stb  (i_wb_stb),
    .i_wb_we   (i_wb_we),
    .i_wb_data (i_wb_data),
    .o_wb_ack  (o_wb_ack),
    .o_wb_data (o_wb_data),
    .o_date    (o_date),
    .o_busy    (o_busy),
    .o_ppy     (o_ppy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;
  int ppy_cnt = 0;

  always @(negedge i_clk) begin
    if (o_ppy === 1'b1) ppy_cnt <= ppy_cnt + 1;
  end

  typedef struct {
    logic [31:0] start;
    int          npd;
    logic [31:0] exp_date;
    int          exp_ppy;
  } vec_t;

  vec_t vecs[14];

  // Reference date model in plain decimal arithmetic
  int mdl_y, mdl_m, mdl_d, mdl_ppy;

  function automatic bit g_leap(input int y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  function automatic int g_dim(input int y, input int m);
    case (m)
      2:             return g_leap(y) ? 29 : 28;
      4, 6, 9, 11:   return 30;
      default:       return 31;
    endcase
  endfunction

  function automatic logic [7:0] bcd8(input int v);
    return 8'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic logic [31:0] mdl_bcd();
    return {bcd8(mdl_y / 100), bcd8(mdl_y % 100), bcd8(mdl_m), bcd8(mdl_d)};
  endfunction

  function automatic void mdl_step();
    if (mdl_d >= g_dim(mdl_y, mdl_m)) begin
      mdl_d = 1;
      if (mdl_m >= 12) begin
        mdl_m = 1;
        mdl_y = (mdl_y + 1) % 10000;
        mdl_ppy++;
      end else begin
        mdl_m++;
      end
    end else begin
      mdl_d++;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All tasks start and end just after a falling edge
  task automatic wb_xfer(input logic we, input logic [31:0] wdata, output logic [31:0] rdata);
    bit got;
    got = 0;
    rdata = 32'h0;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we; i_wb_data = wdata;
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      if (o_wb_ack === 1'b1) begin
        got = 1;
        rdata = o_wb_data;
        break;
      end
    end
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0; i_wb_data = 32'h0;
    check("wb_ack_seen", 32'(got), 32'd1);
    @(negedge i_clk);
    check("wb_ack_single", 32'(o_wb_ack), 32'd0);
  endtask

  task automatic wb_write(input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, d, dummy);
    $display("wb write %h -> date %h", d, o_date);
  endtask

  task automatic wb_read(output logic [31:0] d);
    wb_xfer(1'b0, 32'h0, d);
    $display("wb read  %h", d);
  endtask

  task automatic pulse_ppd();
    i_ppd = 1'b1;
    @(negedge i_clk);
    i_ppd = 1'b0;
  endtask

  task automatic wait_idle();
    int lows;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge i_clk);
      if (o_busy === 1'b0) lows++; else lows = 0;
      if (lows >= 3) break;
    end
    check("idle_reached", 32'(lows >= 3), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    int ppy0;
    int busy_cycles;

    i_rst_n = 1'b0; i_ppd = 1'b0;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0; i_wb_data = 32'h0;

    vecs[0]  = '{32'h20240228, 1, 32'h20240229, 0};
    vecs[1]  = '{32'h20240229, 1, 32'h20240301, 0};
    vecs[2]  = '{32'h21000228, 1, 32'h21000301, 0};
    vecs[3]  = '{32'h20000228, 1, 32'h20000229, 0};
    vecs[4]  = '{32'h20241231, 1, 32'h20250101, 1};
    vecs[5]  = '{32'h99991231, 1, 32'h00000101, 1};
    vecs[6]  = '{32'h20230228, 1, 32'h20230301, 0};
    vecs[7]  = '{32'h20240430, 1, 32'h20240501, 0};
    vecs[8]  = '{32'h20240131, 1, 32'h20240201, 0};
    vecs[9]  = '{32'h20240135, 1, 32'h20240201, 0};
    vecs[10] = '{32'h20240109, 1, 32'h20240110, 0};
    vecs[11] = '{32'h20991231, 1, 32'h21000101, 1};
    vecs[12] = '{32'h20240219, 2, 32'h20240221, 0};
    vecs[13] = '{32'h19000228, 1, 32'h19000301, 0};

    // Reset state
    repeat (3) @(negedge i_clk);
    check("rst_date", o_date, 32'h20240101);
    check("rst_ack", 32'(o_wb_ack), 32'd0);
    check("rst_rdata", o_wb_data, 32'h0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_ppy", 32'(o_ppy), 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("post_rst_date", o_date, 32'h20240101);
    check("post_rst_busy", 32'(o_busy), 32'd0);

    // Directed vector table
    foreach (vecs[i]) begin
      wb_write(vecs[i].start);
      ppy0 = ppy_cnt;
      for (int k = 0; k < vecs[i].npd; k++) begin
        pulse_ppd();
        wait_idle();
      end
      check("vec_date", o_date, vecs[i].exp_date);
      check("vec_ppy", 32'(ppy_cnt - ppy0), 32'(vecs[i].exp_ppy));
      $display("vec %0d: %h +%0d -> %h", i, vecs[i].start, vecs[i].npd, o_date);
    end

    // Ripple timing: day at N+2, month at N+3, busy for 2 cycles
    wb_write(32'h20240229);
    pulse_ppd();
    check("t_n1_busy", 32'(o_busy), 32'd1);
    check("t_n1_date", o_date, 32'h20240229);
    busy_cycles = int'(o_busy);
    @(negedge i_clk);
    check("t_n2_date", o_date, 32'h20240201);
    busy_cycles += int'(o_busy);
    @(negedge i_clk);
    check("t_n3_date", o_date, 32'h20240301);
    busy_cycles += int'(o_busy);
    @(negedge i_clk);
    busy_cycles += int'(o_busy);
    check("t_busy_cycles", 32'(busy_cycles), 32'd2);
    $display("timing seq: date %h busy cycles %0d", o_date, busy_cycles);

    // Year rollover: o_ppy exactly at N+4
    wb_write(32'h20241231);
    pulse_ppd();
    @(negedge i_clk);
    @(negedge i_clk);
    check("y_n3_date", o_date, 32'h20240101);
    check("y_n3_ppy", 32'(o_ppy), 32'd0);
    @(negedge i_clk);
    check("y_n4_date", o_date, 32'h20250101);
    check("y_n4_ppy", 32'(o_ppy), 32'd1);
    @(negedge i_clk);
    check("y_n5_ppy", 32'(o_ppy), 32'd0);
    $display("year seq: date %h", o_date);

    // Masked writes and read-back
    wb_write(32'h20240115);
    wb_write(32'hffff03ff);
    check("mask_mon", o_date, 32'h20240315);
    wb_read(rd);
    check("read_mon", rd, 32'h20240315);
    wb_write(32'h2023ffff);
    check("mask_year", o_date, 32'h20230315);
    wb_write(32'hffffff27);
    check("mask_day", o_date, 32'h20230327);
    wb_read(rd);
    check("read_day", rd, 32'h20230327);

    // Back-to-back strobes: second one queued while busy
    wb_write(32'h20240227);
    i_ppd = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    i_ppd = 1'b0;
    wait_idle();
    check("pending_date", o_date, 32'h20240229);
    $display("pending seq: date %h", o_date);

    // Write during MONTH step aborts the ripple
    wb_write(32'h20241231);
    ppy0 = ppy_cnt;
    pulse_ppd();
    @(negedge i_clk);
    wb_write(32'h20230505);
    check("abort_date", o_date, 32'h20230505);
    wait_idle();
    check("abort_date_hold", o_date, 32'h20230505);
    check("abort_no_ppy", 32'(ppy_cnt - ppy0), 32'd0);
    $display("abort seq: date %h", o_date);

    // Reset during MONTH step
    wb_write(32'h20241231);
    ppy0 = ppy_cnt;
    pulse_ppd();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check("midrst_date", o_date, 32'h20240101);
    check("midrst_busy", 32'(o_busy), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    wait_idle();
    check("midrst_hold", o_date, 32'h20240101);
    check("midrst_no_ppy", 32'(ppy_cnt - ppy0), 32'd0);
    $display("reset seq: date %h", o_date);

    // Randomized runs against the reference model
    for (int r = 0; r < 40; r++) begin
      int dl;
      mdl_y = $urandom_range(9999, 0);
      if ($urandom_range(3, 0) == 0) mdl_y = $urandom_range(99, 0) * 100 + 99;
      mdl_m = ($urandom_range(3, 0) == 0) ? 12 : $urandom_range(12, 1);
      dl = g_dim(mdl_y, mdl_m);
      mdl_d = ($urandom_range(1, 0) == 1) ? dl - $urandom_range(1, 0) : $urandom_range(dl, 1);
      mdl_ppy = 0;
      wb_write(mdl_bcd());
      ppy0 = ppy_cnt;
      for (int b = 0; b < 25; b++) begin
        if ($urandom_range(1, 0) == 1) begin
          i_ppd = 1'b1;
          @(negedge i_clk);
          @(negedge i_clk);
          i_ppd = 1'b0;
          mdl_step();
          mdl_step();
        end else begin
          pulse_ppd();
          mdl_step();
        end
        wait_idle();
        check("rand_date", o_date, mdl_bcd());
      end
      check("rand_ppy", 32'(ppy_cnt - ppy0), 32'(mdl_ppy));
      wb_read(rd);
      check("rand_read", rd, mdl_bcd());
      $display("rand %0d: end date %h model %h", r, o_date, mdl_bcd());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
